rx_bit_seq: RTL and testbench

- Controller that sequences the fsm_sync receive path.
- Synchronises the asynchronous rfin pulse train and decodes each pulse by its width: short pulse is 0, long pulse is 1.
- Issues one-cycle sh_en/sh_data shift strobes to the downstream shift register, counts bits per frame, and flags frame completion.
- Pulses fsm_rst to re-arm fsm_sync on frame end or protocol error.

---
 rtl/rx_bit_seq.sv | 192 +++++++++++++++++++
 tb/tb_rx_bit_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_seq.sv
// ---------------------------------------------------------------------------
// rx_bit_seq
//
// Receive-path sequencer for fsm_sync. Synchronises the asynchronous RF
// envelope pulse train, measures each pulse's high width and decodes it
// (short = 0, long = 1). Each decoded bit is presented to the downstream
// shift register as a one-cycle sh_en/sh_data strobe. Bits are counted per
// frame. A complete frame raises frame_done. A stuck-high pulse or an
// over-long mid-frame gap raises err. Both frame end and error pulse
// fsm_rst to re-arm fsm_sync.
//
// State table:
//   state | meaning
//   IDLE  | waiting for the first rise of a frame; gap is not timed
//   HIGH  | pulse in progress, wcnt measures its width
//   GAP   | between pulses mid-frame, gcnt times the low period
//   DONE  | one cycle after the last bit: frame_done + fsm_rst
//   ERR   | protocol error reported; waits for rfin low before re-arming
//
// Ports:
//   clk        in   system clock (10 MHz nominal)
//   rst        in   synchronous active-high reset
//   rfin       in   asynchronous RF envelope pulse input
//   sh_en      out  one-cycle shift strobe
//   sh_data    out  decoded bit, valid while sh_en=1
//   bit_cnt    out  bits shifted so far in the current frame
//   frame_done out  one-cycle pulse when FRAME_BITS bits have been shifted
//   err        out  one-cycle pulse on width or gap violation
//   fsm_rst    out  one-cycle re-arm pulse to fsm_sync
// ---------------------------------------------------------------------------
module rx_bit_seq #(
    parameter int FRAME_BITS = 8,
    parameter int THRESH     = 3,
    parameter int MAX_HIGH   = 16,
    parameter int GAP_TO     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rfin,
    output logic                              sh_en,
    output logic                              sh_data,
    output logic [$clog2(FRAME_BITS+1)-1:0]   bit_cnt,
    output logic                              frame_done,
    output logic                              err,
    output logic                              fsm_rst
);

    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int WW = $clog2(MAX_HIGH + 1);
    localparam int GW = $clog2(GAP_TO + 1);

    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS);
    localparam logic [WW-1:0] W_MAX      = WW'(MAX_HIGH);
    localparam logic [WW-1:0] W_THRESH   = WW'(THRESH);
    localparam logic [GW-1:0] G_MAX      = GW'(GAP_TO);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIGH = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state, state_nx;

    logic            rfin_m, rfin_s, rfin_d;
    logic            rise;

    logic [WW-1:0]   wcnt, wcnt_nx, wcnt_inc;
    logic [GW-1:0]   gcnt, gcnt_nx, gcnt_inc;
    logic [BW-1:0]   bit_cnt_nx, bit_inc;

    logic            sh_en_nx, sh_data_nx, frame_done_nx, err_nx, fsm_rst_nx;

    assign rise = rfin_s & ~rfin_d;

    // Saturating increments; the FSM leaves HIGH/GAP on reaching the limit,
    // so saturation only guards against wrap if that ever changes.
    assign wcnt_inc = (wcnt == W_MAX) ? wcnt : wcnt + WW'(1);
    assign gcnt_inc = (gcnt == G_MAX) ? gcnt : gcnt + GW'(1);
    assign bit_inc  = bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rfin_m     <= 1'b0;
            rfin_s     <= 1'b0;
            rfin_d     <= 1'b0;
            state      <= S_IDLE;
            wcnt       <= '0;
            gcnt       <= '0;
            bit_cnt    <= '0;
            sh_en      <= 1'b0;
            sh_data    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            fsm_rst    <= 1'b0;
        end else begin
            rfin_m     <= rfin;
            rfin_s     <= rfin_m;
            rfin_d     <= rfin_s;
            state      <= state_nx;
            wcnt       <= wcnt_nx;
            gcnt       <= gcnt_nx;
            bit_cnt    <= bit_cnt_nx;
            sh_en      <= sh_en_nx;
            sh_data    <= sh_data_nx;
            frame_done <= frame_done_nx;
            err        <= err_nx;
            fsm_rst    <= fsm_rst_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        wcnt_nx       = wcnt;
        gcnt_nx       = gcnt;
        bit_cnt_nx    = bit_cnt;
        sh_en_nx      = 1'b0;
        sh_data_nx    = 1'b0;
        frame_done_nx = 1'b0;
        err_nx        = 1'b0;
        fsm_rst_nx    = 1'b0;

        case (state)
            S_IDLE: begin
                gcnt_nx = '0;
                if (rise) begin
                    state_nx = S_HIGH;
                    wcnt_nx  = WW'(1);
                end
            end

            S_HIGH: begin
                if (rfin_s) begin
                    wcnt_nx = wcnt_inc;
                    if (wcnt_inc == W_MAX) begin
                        // Stuck high: report now, no bit for this pulse.
                        state_nx   = S_ERR;
                        err_nx     = 1'b1;
                        fsm_rst_nx = 1'b1;
                        bit_cnt_nx = '0;
                    end
                end else begin
                    sh_en_nx   = 1'b1;
                    sh_data_nx = (wcnt >= W_THRESH);
                    bit_cnt_nx = bit_inc;
                    if (bit_inc == FRAME_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_GAP;
                        gcnt_nx  = '0;
                    end
                end
            end

            S_GAP: begin
                gcnt_nx = gcnt_inc;
                // A rise arriving on the timeout cycle still counts as a bit.
                if (rise) begin
                    state_nx = S_HIGH;
                    wcnt_nx  = WW'(1);
                end else if (gcnt_inc == G_MAX) begin
                    state_nx   = S_ERR;
                    err_nx     = 1'b1;
                    fsm_rst_nx = 1'b1;
                    bit_cnt_nx = '0;
                end
            end

            S_DONE: begin
                // Any rise seen here is dropped; rfin_d absorbs it, so the
                // next frame needs a fresh rise in IDLE.
                frame_done_nx = 1'b1;
                fsm_rst_nx    = 1'b1;
                bit_cnt_nx    = '0;
                state_nx      = S_IDLE;
            end

            S_ERR: begin
                if (!rfin_s) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_bit_seq.sv
module tb_rx_bit_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rfin = 1'b0;
    logic       sh_en, sh_data, frame_done, err, fsm_rst;
    logic [3:0] bit_cnt;

    rx_bit_seq #(
        .FRAME_BITS(8),
        .THRESH    (3),
        .MAX_HIGH  (16),
        .GAP_TO    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rfin      (rfin),
        .sh_en     (sh_en),
        .sh_data   (sh_data),
        .bit_cnt   (bit_cnt),
        .frame_done(frame_done),
        .err       (err),
        .fsm_rst   (fsm_rst)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = sh_en, 1 = frame_done, 2 = err
    typedef struct {
        int kind;
        bit data;
        int bcnt;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_bits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input bit data, input int bcnt, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.bcnt = bcnt;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // Caller sits at a negedge; rfin high for w cycles then low for g cycles.
    task automatic pulse(input int w, input int g, input bit d);
        rfin = 1'b1;
        repeat (w) @(negedge clk);
        rfin = 1'b0;
        exp_bits++;
        push_exp(0, d, exp_bits, cyc + 3);
        if (exp_bits == 8) begin
            push_exp(1, 1'b0, 0, cyc + 4);
            exp_bits = 0;
        end
        repeat (g) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        if (sh_en | frame_done | err | fsm_rst) begin
            chk("fsm_rst_pairing", 32'(fsm_rst), 32'(frame_done | err));
            chk("exclusive", 32'(int'(sh_en) + int'(frame_done) + int'(err) <= 1), 32'd1);
            if (sh_en | frame_done | err) begin
                k = sh_en ? 0 : (frame_done ? 1 : 2);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d, none required", k, cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("event_bit_cnt", 32'(bit_cnt), 32'(e.bcnt));
                    if (e.kind == 0) chk("sh_data", 32'(sh_data), 32'(e.data));
                end
            end
        end
    end

    int widths[8] = '{1, 4, 1, 4, 4, 1, 1, 4};
    bit bits_x[8] = '{0, 1, 0, 1, 1, 0, 0, 1};

    initial begin
        int n;

        // Reset with rfin toggling
        @(negedge clk);
        rfin = 1'b1;
        chk("rst_sh_en", 32'(sh_en), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rfin = 1'b0;
        chk("rst_bit_cnt", 32'(bit_cnt), 0);
        chk("rst_outputs", 32'({sh_en, sh_data, frame_done, err, fsm_rst}), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single short pulse, then left to time out in GAP
        pulse(1, 0, 1'b0);
        push_exp(2, 1'b0, 0, cyc + 35);
        exp_bits = 0;
        repeat (6) @(negedge clk);
        chk("single_bit_cnt", 32'(bit_cnt), 1);
        repeat (40) @(negedge clk);
        chk("single_after_err_bit_cnt", 32'(bit_cnt), 0);

        // Full frame
        for (int i = 0; i < 8; i++) pulse(widths[i], 5, bits_x[i]);
        repeat (10) @(negedge clk);
        chk("frame_idle_bit_cnt", 32'(bit_cnt), 0);

        // Stuck high: err when wcnt reaches 16
        rfin = 1'b1;
        push_exp(2, 1'b0, 0, cyc + 18);
        repeat (20) @(negedge clk);
        rfin = 1'b0;
        repeat (10) @(negedge clk);

        // Gap timeout after 3 valid bits
        pulse(1, 5, 1'b0);
        pulse(4, 5, 1'b1);
        pulse(3, 0, 1'b1);
        push_exp(2, 1'b0, 0, cyc + 35);
        exp_bits = 0;
        repeat (40) @(negedge clk);
        chk("gap_to_bit_cnt", 32'(bit_cnt), 0);

        // Mid-frame reset while in HIGH after 5 bits
        for (int i = 0; i < 5; i++) pulse(4, 5, 1'b1);
        rfin = 1'b1;
        repeat (6) @(negedge clk);
        rst  = 1'b1;
        rfin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_bits = 0;
        chk("midrst_bit_cnt", 32'(bit_cnt), 0);
        chk("midrst_outputs", 32'({sh_en, frame_done, err, fsm_rst}), 0);
        repeat (5) @(negedge clk);
        chk("midrst_quiet_bit_cnt", 32'(bit_cnt), 0);

        // Next frame completes normally
        for (int i = 0; i < 8; i++) pulse(widths[i], 5, bits_x[i]);

        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event: kind %0d required at cycle %0d, not seen", e.kind, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
